// File: rtl/pulse_width_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// default widths used by the top level and its counters.
package pulse_width_gen_pkg;

  localparam int unsigned PWG_CNT_W_DEFAULT     = 8;
  localparam int unsigned PWG_MIN_WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwg_state_e;

endpackage

// File: rtl/pulse_width_cnt.sv
// Loadable down-counter with a zero flag. A load always wins over enable,
// and the count saturates at zero so a stray enable can never wrap it.
module pulse_width_cnt
  import pulse_width_gen_pkg::*;
#(
  parameter int unsigned W = PWG_CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_width_gen.sv
// Pulse train generator: accepts a request (high width, low width, pulse
// count), validates it, then emits count pulses of the latched shape on a
// registered output. Abort ends a train early without a done strobe;
// rejected requests pulse err and toggle the ntfr notifier.
module pulse_width_gen
  import pulse_width_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = PWG_CNT_W_DEFAULT,
  parameter int unsigned MIN_WIDTH = PWG_MIN_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_high,
  input  logic [CNT_W-1:0] req_low,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ntfr
);

  localparam logic [CNT_W-1:0] MinWidthL = CNT_W'(MIN_WIDTH);

  pwg_state_e       state_q;
  pwg_state_e       state_d;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] high_d;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] low_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             done_q;
  logic             done_d;
  logic             err_q;
  logic             err_d;
  logic             ntfr_q;
  logic             ntfr_d;

  logic             accept;
  logic             legal;

  logic             phase_load;
  logic             phase_en;
  logic [CNT_W-1:0] phase_val;
  logic             phase_zero;

  logic             train_load;
  logic             train_en;
  logic [CNT_W-1:0] train_val;
  logic             train_zero;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign legal     = (req_high >= MinWidthL) && (req_low != '0) && (req_count != '0);

  // Cycles remaining in the current HIGH or LOW phase (loaded with width-1).
  pulse_width_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (phase_load),
    .en_i       (phase_en),
    .load_val_i (phase_val),
    .zero_o     (phase_zero)
  );

  // Pulses remaining after the current one (loaded with count-1).
  pulse_width_cnt #(.W(CNT_W)) u_train_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (train_load),
    .en_i       (train_en),
    .load_val_i (train_val),
    .zero_o     (train_zero)
  );

  // Next-state and strobe logic; abort is checked before any end-of-phase move.
  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    low_d      = low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ntfr_d     = ntfr_q;
    phase_load = 1'b0;
    phase_en   = 1'b0;
    phase_val  = '0;
    train_load = 1'b0;
    train_en   = 1'b0;
    train_val  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d    = HIGH;
            high_d     = req_high;
            low_d      = req_low;
            phase_load = 1'b1;
            phase_val  = req_high - CNT_W'(1);
            train_load = 1'b1;
            train_val  = req_count - CNT_W'(1);
          end else begin
            err_d  = 1'b1;
            ntfr_d = ~ntfr_q;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_zero) begin
          state_d    = LOW;
          phase_load = 1'b1;
          phase_val  = low_q - CNT_W'(1);
        end else begin
          phase_en = 1'b1;
        end
      end

      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_zero) begin
          if (train_zero) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = HIGH;
            phase_load = 1'b1;
            phase_val  = high_q - CNT_W'(1);
            train_en   = 1'b1;
          end
        end else begin
          phase_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The output is registered from the next state so it tracks HIGH exactly.
  assign pulse_d = (state_d == HIGH);

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      high_q  <= '0;
      low_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ntfr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ntfr_q  <= ntfr_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign ntfr      = ntfr_q;

endmodule

// File: tb/tb_pulse_width_gen.sv
// Scoreboard bench for pulse_width_gen: stimulus pushes the expected
// per-cycle output record for every cycle after acceptance; a monitor on
// the falling edge pops and compares, and flags any activity while idle.
module tb_pulse_width_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_high = 8'd0;
  logic [7:0] req_low = 8'd0;
  logic [7:0] req_count = 8'd0;
  logic       abort = 1'b0;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic       err;
  logic       ntfr;

  // Record bits: {pulse_out, busy, done, err, ntfr, req_ready}
  typedef struct {
    logic [5:0] exp;
    string      tag;
  } rec_t;

  rec_t       expQ[$];
  rec_t       curRec;
  logic [5:0] act;
  int         total = 0;
  int         bad = 0;
  logic       ntfrModel = 1'b0;
  bit         monOn = 1'b0;

  pulse_width_gen dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_high  (req_high),
    .req_low   (req_low),
    .req_count (req_count),
    .abort     (abort),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ntfr      (ntfr)
  );

  always #5 clk = ~clk;

  // Monitor: compare one expected record per cycle, otherwise demand silence.
  always @(negedge clk) begin
    if (monOn) begin
      act = {pulse_out, busy, done, err, ntfr, req_ready};
      if (expQ.size() > 0) begin
        curRec = expQ.pop_front();
        total++;
        if (act !== curRec.exp) begin
          bad++;
          $display("[TB] FAIL %s: got pbdenr=%b want %b", curRec.tag, act, curRec.exp);
        end
      end else if (act[5:2] !== 4'b0000) begin
        total++;
        bad++;
        $display("[TB] FAIL idle: got pbde=%b want 0000", act[5:2]);
      end
    end
  end

  function automatic void pushRec(input logic p, input logic b, input logic d,
                                  input logic e, input string tag);
    rec_t r;
    r.exp = {p, b, d, e, ntfrModel, ~b};
    r.tag = tag;
    expQ.push_back(r);
  endfunction

  // Expected train shape; stopAt > 0 truncates it (abort/reset) with no done.
  task automatic pushTrain(input int h, input int l, input int c, input int stopAt,
                           input string tag);
    int cyc = 0;
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < h; i++) begin
        cyc++;
        if (stopAt > 0 && cyc > stopAt) return;
        pushRec(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("%s hi c%0d", tag, cyc));
      end
      for (int i = 0; i < l; i++) begin
        cyc++;
        if (stopAt > 0 && cyc > stopAt) return;
        pushRec(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s lo c%0d", tag, cyc));
      end
    end
    if (stopAt == 0) pushRec(1'b0, 1'b0, 1'b1, 1'b0, $sformatf("%s done", tag));
  endtask

  // Present a request for one cycle, then scramble the fields to prove latching.
  task automatic offer(input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    req_valid = 1'b1;
    req_high  = h;
    req_low   = l;
    req_count = c;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_high  = 8'd1;
    req_low   = 8'd0;
    req_count = 8'd0;
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] l,
                               input logic [7:0] c, input string tag);
    offer(h, l, c);
    if (h >= 8'd6 && l != 8'd0 && c != 8'd0) begin
      pushTrain(int'(h), int'(l), int'(c), 0, tag);
    end else begin
      ntfrModel = ~ntfrModel;
      pushRec(1'b0, 1'b0, 1'b0, 1'b1, {tag, " err"});
      pushRec(1'b0, 1'b0, 1'b0, 1'b0, {tag, " after"});
    end
  endtask

  // Wait until every expected record has been consumed, bounded by a budget.
  task automatic checkOutput(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d records left want 0", expQ.size());
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic abortTest(input logic [7:0] h, input logic [7:0] l, input logic [7:0] c,
                           input int at, input string tag);
    offer(h, l, c);
    pushTrain(int'(h), int'(l), int'(c), at, tag);
    pushRec(1'b0, 1'b0, 1'b0, 1'b0, {tag, " idle"});
    repeat (at - 1) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput(100);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    monOn = 1'b1;
    pushRec(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    pushRec(1'b0, 1'b0, 1'b0, 1'b0, "reset+1");
    checkOutput(10);

    applyStimulus(8'd6, 8'd2, 8'd3, "legal632");
    checkOutput(100);
    applyStimulus(8'd5, 8'd2, 8'd1, "high5a");
    checkOutput(10);
    applyStimulus(8'd5, 8'd2, 8'd1, "high5b");
    checkOutput(10);
    applyStimulus(8'd6, 8'd0, 8'd1, "low0");
    checkOutput(10);
    applyStimulus(8'd6, 8'd2, 8'd0, "count0");
    checkOutput(10);

    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;

    applyStimulus(8'd7, 8'd3, 8'd2, "legal732");
    checkOutput(100);
    applyStimulus(8'd6, 8'd1, 8'd1, "minwidth");
    checkOutput(100);

    abortTest(8'd8, 8'd4, 8'd2, 10, "abort842");
    abortTest(8'd6, 8'd2, 8'd1, 6, "abortEndHigh");
    abortTest(8'd6, 8'd2, 8'd1, 8, "abortEndLow");

    applyStimulus(8'd0, 8'd1, 8'd1, "high0");
    checkOutput(10);

    offer(8'd6, 8'd2, 8'd3);
    pushTrain(6, 2, 3, 10, "rstMid");
    ntfrModel = 1'b0;
    pushRec(1'b0, 1'b0, 1'b0, 1'b0, "rstMid cleared");
    pushRec(1'b0, 1'b0, 1'b0, 1'b0, "rstMid released");
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput(100);

    applyStimulus(8'd255, 8'd255, 8'd1, "max255");
    checkOutput(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
